// File: rtl/mips_multicycle_ctrl_pkg.sv
// ============================================================================
// Module  : mips_multicycle_ctrl_pkg
// Brief   : Shared encodings for the multi-cycle MIPS controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BEQ_EX   = 4'd8,
        ADDI_EX  = 4'd9,
        ADDI_WB  = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_REG    = 1'b1;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic is_supported_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_alu_ctrl_decode.sv
// ============================================================================
// Module  : alu_ctrl_decode
// Brief   : R-type funct field to ALU control code, with legality flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_ctrl_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: legal    = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// Module  : mips_multicycle_ctrl
// Brief   : Multi-cycle MIPS main controller (fetch/decode/execute/mem/wb).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       iord,
    output logic       mem_req,
    output logic       mem_we,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     cur;
    logic [3:0] fn_alu;
    logic       fn_legal;

    alu_ctrl_decode u_alu_ctrl_decode (
        .funct    (funct),
        .alu_ctrl (fn_alu),
        .legal    (fn_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:    if (mem_ready) cur <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_RTYPE:     cur <= RTYPE_EX;
                        OP_LW, OP_SW: cur <= MEMADR;
                        OP_BEQ:       cur <= BEQ_EX;
                        OP_ADDI:      cur <= ADDI_EX;
                        OP_J:         cur <= JUMP;
                        default:      cur <= FETCH;
                    endcase
                end
                MEMADR:   cur <= (opcode == OP_LW) ? MEMRD : MEMWR;
                MEMRD:    if (mem_ready) cur <= MEMWB;
                MEMWB:    cur <= FETCH;
                MEMWR:    if (mem_ready) cur <= FETCH;
                RTYPE_EX: cur <= fn_legal ? RTYPE_WB : FETCH;
                RTYPE_WB: cur <= FETCH;
                BEQ_EX:   cur <= FETCH;
                ADDI_EX:  cur <= ADDI_WB;
                ADDI_WB:  cur <= FETCH;
                JUMP:     cur <= FETCH;
                default:  cur <= FETCH;
            endcase
        end
    end

    // Reset gates the decode directly so outputs drop without waiting for a clock.
    always_comb begin
        alu_ctrl   = ALU_ADD;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        pc_src     = PC_ALU;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        iord       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        illegal    = 1'b0;
        state      = 4'd0;
        if (reset) begin
            alu_ctrl = 4'd0;
        end else begin
            state = cur;
            case (cur)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b = SRCB_IMMSH2;
                    illegal   = !is_supported_op(opcode);
                end
                MEMADR: begin
                    alu_src_a = SRCA_REG;
                    alu_src_b = SRCB_IMM;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                RTYPE_EX: begin
                    alu_src_a = SRCA_REG;
                    alu_ctrl  = fn_alu;
                    illegal   = !fn_legal;
                end
                RTYPE_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    alu_ctrl  = fn_alu;
                end
                BEQ_EX: begin
                    alu_src_a = SRCA_REG;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = PC_ALUOUT;
                    pc_write  = zero;
                end
                ADDI_EX: begin
                    alu_src_a = SRCA_REG;
                    alu_src_b = SRCB_IMM;
                end
                ADDI_WB:  reg_write = 1'b1;
                JUMP: begin
                    pc_src   = PC_JUMP;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
// Module  : tb_mips_multicycle_ctrl
// Brief   : Instruction-level reference model checking every controller cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl;
    import mips_multicycle_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic [3:0] alu_ctrl, state;
    logic       alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic       pc_write, ir_write, reg_write, reg_dst, mem_to_reg;
    logic       iord, mem_req, mem_we, illegal;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .alu_ctrl(alu_ctrl),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .iord(iord),
        .mem_req(mem_req), .mem_we(mem_we), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    logic [21:0] dut_vec;
    assign dut_vec = {state, alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_write, ir_write,
                      reg_write, reg_dst, mem_to_reg, iord, mem_req, mem_we, illegal};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5,
                   K_BADOP = 6, K_BADFN = 7;

    // {legal, code} straight from the ALU funct table
    function automatic logic [4:0] fn_map(input logic [5:0] f);
        case (f)
            6'b100000: return 5'b1_0010;
            6'b100010: return 5'b1_0110;
            6'b100100: return 5'b1_0000;
            6'b100101: return 5'b1_0001;
            6'b101010: return 5'b1_0111;
            default:   return 5'b0_0010;
        endcase
    endfunction

    function automatic logic [21:0] expect_vec(input state_t p, input int kind,
                                               input logic [5:0] f, input logic z,
                                               input logic rdy);
        logic [3:0] alu;
        logic       a, pcw, irw, rw, rd, m2r, io, mr, we, ill;
        logic [1:0] b, pcs;
        logic [4:0] fm;
        alu = 4'b0010; a = 0; b = 0; pcs = 0;
        pcw = 0; irw = 0; rw = 0; rd = 0; m2r = 0; io = 0; mr = 0; we = 0; ill = 0;
        fm = fn_map(f);
        case (p)
            FETCH:    begin mr = 1; b = 2'b01; irw = rdy; pcw = rdy; end
            DECODE:   begin b = 2'b11; ill = (kind == K_BADOP); end
            MEMADR:   begin a = 1; b = 2'b10; end
            MEMRD:    begin mr = 1; io = 1; end
            MEMWB:    begin rw = 1; m2r = 1; end
            MEMWR:    begin mr = 1; we = 1; io = 1; end
            RTYPE_EX: begin a = 1; alu = fm[3:0]; ill = !fm[4]; end
            RTYPE_WB: begin rw = 1; rd = 1; alu = fm[3:0]; end
            BEQ_EX:   begin a = 1; alu = 4'b0110; pcs = 2'b01; pcw = z; end
            ADDI_EX:  begin a = 1; b = 2'b10; end
            ADDI_WB:  rw = 1;
            JUMP:     begin pcs = 2'b10; pcw = 1; end
            default:  ;
        endcase
        return {4'(p), alu, a, b, pcs, pcw, irw, rw, rd, m2r, io, mr, we, ill};
    endfunction

    function automatic bit known_op(input logic [5:0] o);
        return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
               o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
    endfunction

    // One instruction: directed = mem_ready high except forced MEMRD stalls.
    task automatic run_instr(input int kind, input logic [5:0] f, input bit directed,
                             input int rd_stalls, input int zsel, input bit abort_rd);
        state_t     ph[$];
        state_t     p;
        logic [5:0] op;
        logic       rdy;
        int         stalls = rd_stalls;
        ph.push_back(FETCH);
        ph.push_back(DECODE);
        case (kind)
            K_R:     begin op = 6'b000000; ph.push_back(RTYPE_EX); ph.push_back(RTYPE_WB); end
            K_BADFN: begin op = 6'b000000; ph.push_back(RTYPE_EX); end
            K_LW:    begin op = 6'b100011; ph.push_back(MEMADR); ph.push_back(MEMRD); ph.push_back(MEMWB); end
            K_SW:    begin op = 6'b101011; ph.push_back(MEMADR); ph.push_back(MEMWR); end
            K_BEQ:   begin op = 6'b000100; ph.push_back(BEQ_EX); end
            K_ADDI:  begin op = 6'b001000; ph.push_back(ADDI_EX); ph.push_back(ADDI_WB); end
            K_J:     begin op = 6'b000010; ph.push_back(JUMP); end
            default: begin
                op = 6'b111111;
                if (!directed) while (known_op(op)) op = 6'($urandom);
            end
        endcase
        while (ph.size() > 0) begin
            @(negedge clk);
            p = ph[0];
            if (p == FETCH) begin opcode = op; funct = f; end
            rdy = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (p == MEMRD && (stalls > 0 || abort_rd)) begin rdy = 1'b0; stalls--; end
            mem_ready = rdy;
            zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            #1 chk($sformatf("k%0d_%s", kind, p.name()), dut_vec, expect_vec(p, kind, f, zero, rdy));
            if (p == MEMRD && abort_rd) begin
                #2 reset = 1'b1;
                #1 chk("rst_async_drop", dut_vec, 22'd0);
                @(posedge clk);
                #1 chk("rst_hold", dut_vec, 22'd0);
                @(negedge clk);
                #1 reset = 1'b0;
                #1 chk("rst_restart_fetch", dut_vec, expect_vec(FETCH, kind, f, 1'b0, 1'b0));
                return;
            end
            if (!((p == FETCH || p == MEMRD || p == MEMWR) && !rdy)) void'(ph.pop_front());
        end
    endtask

    initial begin
        logic [5:0] legal_fn [5];
        logic [5:0] f;
        int         k;
        legal_fn[0] = 6'b100000; legal_fn[1] = 6'b100010; legal_fn[2] = 6'b100100;
        legal_fn[3] = 6'b100101; legal_fn[4] = 6'b101010;
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        #1 chk("reset_outs", dut_vec, 22'd0);
        mem_ready = 1'b1; zero = 1'b1;
        @(negedge clk);
        #1 chk("reset_outs_ready", dut_vec, 22'd0);
        mem_ready = 1'b0; zero = 1'b0;
        #1 reset = 1'b0;
        #1 chk("first_fetch", dut_vec, expect_vec(FETCH, K_R, 6'd0, 1'b0, 1'b0));

        run_instr(K_R,     6'b100010, 1, 0, -1, 0);
        run_instr(K_LW,    6'd0,      1, 3, -1, 0);
        run_instr(K_BEQ,   6'd0,      1, 0,  1, 0);
        run_instr(K_BEQ,   6'd0,      1, 0,  0, 0);
        run_instr(K_BADOP, 6'd0,      1, 0, -1, 0);
        run_instr(K_BADFN, 6'b000000, 1, 0, -1, 0);
        run_instr(K_SW,    6'd0,      1, 0, -1, 0);
        run_instr(K_J,     6'd0,      1, 0, -1, 0);
        run_instr(K_ADDI,  6'd0,      1, 0, -1, 0);
        run_instr(K_LW,    6'd0,      1, 0, -1, 1);
        run_instr(K_R,     6'b101010, 1, 0, -1, 0);

        for (int i = 0; i < 300; i++) begin
            k = int'($urandom_range(0, 7));
            f = 6'($urandom);
            if (k == K_R) f = legal_fn[$urandom_range(0, 4)];
            if (k == K_BADFN) while (fn_map(f) >= 5'h10) f = 6'($urandom);
            run_instr(k, f, 0, 0, -1, (k == K_LW) && ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle main controller for the MIPS datapath: the sequencer that drives the ALU's 4-bit `ctrl` input and every datapath enable and mux select. It steps fetch/decode/execute/memory/writeback, decodes `opcode` and `funct` into ALU operation codes, and stalls on a single-ported memory ready handshake. It sits beside the datapath and consumes the ALU `zero` flag for branch resolution.

## Interface
- No parameters; widths are fixed by the MIPS ISA.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces `FETCH` and gates all outputs low while high.
- `opcode`  in  6  IR[31:26], stable from `DECODE` until the next `FETCH`.
- `funct`  in  6  IR[5:0], same stability.
- `zero`  in  1  ALU zero flag, same cycle.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `alu_ctrl`  out  4  codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- `alu_src_a`  out  1  0 = PC, 1 = reg A.
- `alu_src_b`  out  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pc_write`, `ir_write`, `reg_write`, `reg_dst`, `mem_to_reg`, `iord`, `mem_req`, `mem_we`  out  1 each  datapath enables and selects.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `state`  out  4  current state encoding, for debug.

## Operation
- Outputs are decoded from state only, except the write strobes: `ir_write`/`pc_write` in `FETCH` are qualified by `mem_ready`, and `pc_write` in `BEQ_EX` is qualified by `zero`.
- Signals not listed for a state are 0. `alu_ctrl` defaults to ADD (0010).
- `FETCH`: `mem_req`; a=0, b=01, ADD, pc_src=00. Hold until `mem_ready`, then pulse `ir_write` and `pc_write` and go to `DECODE`.
- `DECODE`: a=0, b=11, ADD (branch target into ALUOut). Next state by opcode:
  - 000000 → `RTYPE_EX`; 100011 or 101011 → `MEMADR`; 000100 → `BEQ_EX`; 001000 → `ADDI_EX`; 000010 → `JUMP`.
  - Any other opcode → `FETCH` with `illegal`=1.
- `MEMADR`: a=1, b=10, ADD. Go to `MEMRD` for lw, `MEMWR` for sw.
- `MEMRD`: `mem_req`, `iord`; hold until `mem_ready`, then go to `MEMWB`.
- `MEMWB`: `reg_write`, reg_dst=0, mem_to_reg=1; then `FETCH`.
- `MEMWR`: `mem_req`, `mem_we`, `iord`; hold until `mem_ready`, then `FETCH`.
- `RTYPE_EX`: a=1, b=00. Funct map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - Legal funct → `RTYPE_WB`.
  - Illegal funct → `illegal`=1, go to `FETCH`, no register write.
- `RTYPE_WB`: `reg_write`, reg_dst=1, mem_to_reg=0, `alu_ctrl` still the funct code; then `FETCH`.
- `BEQ_EX`: a=1, b=00, SUB, pc_src=01, pc_write=`zero`; then `FETCH`.
- `ADDI_EX`: a=1, b=10, ADD; then `ADDI_WB`.
- `ADDI_WB`: `reg_write`, reg_dst=0, mem_to_reg=0; then `FETCH`.
- `JUMP`: pc_src=10, `pc_write`; then `FETCH`.

## Timing
- Reset value of every output is 0 while `reset` is high. The state register resets to `FETCH`.
- First `mem_req` is in the first cycle after `reset` deasserts.
- Latency with `mem_ready` tied high: R-type 4, lw 5, sw 4, addi 4, beq 3, j 3 cycles.
  - Each low-`mem_ready` cycle in `FETCH`, `MEMRD` or `MEMWR` adds one cycle.
  - Every stalled state holds all of its outputs constant.
- `mem_req` remains asserted until the cycle in which `mem_ready` is seen; there is no request abort.
- `mem_ready` asserted outside `FETCH`, `MEMRD` and `MEMWR` is ignored.
- `illegal` rises in the same cycle the FSM leaves `DECODE`/`RTYPE_EX` for `FETCH`.
- Reset asserted mid-instruction (including mid-stall) drops all outputs in the same cycle (asynchronous). Execution restarts at `FETCH`; no partial write is issued.

## Structure
- Shared package/header: state encodings (4-bit), opcode and funct constants, ALU ctrl codes (the same values the ALU decodes), and mux-select encodings.
- One sub-module, `alu_ctrl_decode`: combinational funct → {`alu_ctrl`, `legal`}, instantiated once.

## Test plan
- Reset mid-`MEMRD` with `mem_ready`=0 → outputs 0 immediately; after release the FSM is in `FETCH` with `mem_req`=1 and no `reg_write` was ever pulsed.
- R-type funct 100010, `mem_ready`=1 → states FETCH, DECODE, RTYPE_EX, RTYPE_WB; `alu_ctrl`=0110 in EX and WB; `reg_write`=1 and `reg_dst`=1 only in WB.
- lw with `mem_ready` low for 3 cycles in `MEMRD` → 8 cycles total; `iord` and `mem_req` held; `mem_to_reg`=1 and `reg_write` in `MEMWB`.
- beq with `zero`=1 → `pc_write`=1 and `pc_src`=01 in `BEQ_EX`; with `zero`=0 → `pc_write`=0; both return to `FETCH` in 3 cycles.
- Opcode 111111 → `illegal` one-cycle pulse leaving `DECODE`. Funct 000000 → `illegal` leaving `RTYPE_EX`. Neither asserts `reg_write`.
- sw, then j, back to back → sw: `mem_we` with `mem_ready`, 4 cycles; j: `pc_src`=10 and `pc_write` in `JUMP`, 3 cycles.
